// File: rtl/crc_lut_engine.sv
// crc_lut_engine: run-time generated CRC lookup table with independent registered read ports
module crc_lut_engine #(
  parameter int CRC_W     = 32,
  parameter int IDX_W     = 8,
  parameter int NUM_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [CRC_W-1:0]             cfg_poly,
  input  logic                         cfg_refl,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         tbl_valid,
  input  logic [NUM_PORTS-1:0]         rd_en,
  input  logic [NUM_PORTS*IDX_W-1:0]   rd_addr,
  output logic [NUM_PORTS-1:0]         rd_vld,
  output logic [NUM_PORTS*CRC_W-1:0]   rd_data,
  output logic                         rd_err
);
  localparam int BW    = IDX_W > 1 ? $clog2(IDX_W) : 1;
  localparam int DEPTH = 1 << IDX_W;
  typedef enum logic [1:0] {IDLE, GEN, READY} state_t;
  state_t            state, state_nx;
  logic [CRC_W-1:0]  poly_q, rp, c_q, c_cur, c_nx;
  logic              refl_q;
  logic [IDX_W-1:0]  idx;
  logic [BW-1:0]     bitc;
  logic [CRC_W-1:0]  mem [DEPTH];
  logic              go, last_bit, last;
  // start is honoured only outside GEN; last marks the final shift of the final entry
  assign go       = start && state != GEN;
  assign last_bit = bitc == BW'(IDX_W-1);
  assign last     = state == GEN && last_bit && idx == '1;
  // bit-reversed polynomial used by the reflected (LSB-first) table
  always_comb begin
    rp = '0;
    for (int i = 0; i < CRC_W; i++) rp[i] = poly_q[CRC_W-1-i];
  end
  // one shift step per cycle; each entry is seeded from its index on its first step
  always_comb begin
    c_cur = bitc == '0 ? (refl_q ? CRC_W'(idx) : CRC_W'(idx) << (CRC_W-IDX_W)) : c_q;
    c_nx  = refl_q ? (c_cur[0] ? (c_cur >> 1) ^ rp : c_cur >> 1)
                   : (c_cur[CRC_W-1] ? (c_cur << 1) ^ poly_q : c_cur << 1);
  end
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  // next-state logic
  always_comb state_nx = go ? GEN : last ? READY : state;
  // state-decoded outputs
  always_comb busy = state == GEN;
  // configuration capture, entry/bit counters and completion flags
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      poly_q    <= '0;
      refl_q    <= 1'b0;
      idx       <= '0;
      bitc      <= '0;
      c_q       <= '0;
      done      <= 1'b0;
      tbl_valid <= 1'b0;
    end else begin
      done <= last;
      if (go) begin
        poly_q    <= cfg_poly;
        refl_q    <= cfg_refl;
        idx       <= '0;
        bitc      <= '0;
        tbl_valid <= 1'b0;
      end else if (state == GEN) begin
        c_q  <= c_nx;
        bitc <= last_bit ? '0 : bitc + 1'b1;
        idx  <= last_bit ? idx + 1'b1 : idx;
        if (last) tbl_valid <= 1'b1;
      end
    end
  // table write on the final shift of each entry; storage is deliberately not reset
  always_ff @(posedge clk)
    if (state == GEN && last_bit) mem[idx] <= c_nx;
  // per-port registered lookups; requests while the table is offline raise a sticky error
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_vld  <= '0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_vld[p] <= rd_en[p] && tbl_valid;
        if (rd_en[p] && tbl_valid) rd_data[p*CRC_W +: CRC_W] <= mem[rd_addr[p*IDX_W +: IDX_W]];
      end
      rd_err <= rd_err | (|rd_en && !tbl_valid);
    end
endmodule

// File: tb/tb_crc_lut_engine.sv
// tb_crc_lut_engine: directed checks of table generation, lookups, regeneration and reset
module tb_crc_lut_engine;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] cfg_poly = '0;
  logic        cfg_refl = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, tbl_valid, rd_err;
  logic [1:0]  rd_en = '0;
  logic [15:0] rd_addr = '0;
  logic [1:0]  rd_vld;
  logic [63:0] rd_data;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mt [256];

  crc_lut_engine #(.CRC_W(32), .IDX_W(8), .NUM_PORTS(2)) dut (
    .clk(clk), .rstn(rstn), .cfg_poly(cfg_poly), .cfg_refl(cfg_refl), .start(start),
    .busy(busy), .done(done), .tbl_valid(tbl_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_vld(rd_vld), .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] entry(input logic [31:0] poly, input logic refl, input int i);
    logic [31:0] c, r;
    for (int b = 0; b < 32; b++) r[b] = poly[31-b];
    c = refl ? 32'(i) : 32'(i) << 24;
    for (int s = 0; s < 8; s++)
      c = refl ? (c[0] ? (c >> 1) ^ r : c >> 1) : (c[31] ? (c << 1) ^ poly : c << 1);
    return c;
  endfunction

  task automatic build(input logic [31:0] poly, input logic refl);
    for (int i = 0; i < 256; i++) mt[i] = entry(poly, refl, i);
  endtask

  task automatic rd2(input logic [7:0] a0, input logic [7:0] a1, output logic [31:0] d0, output logic [31:0] d1);
    @(negedge clk);
    rd_en = 2'b11;
    rd_addr = {a1, a0};
    @(negedge clk);
    rd_en = 2'b00;
    chk("rd2_vld", 64'(rd_vld), 64'h3);
    d0 = rd_data[31:0];
    d1 = rd_data[63:32];
  endtask

  task automatic gen(input logic [31:0] p, input logic r, input bit wild);
    int n, dn;
    @(negedge clk);
    cfg_poly = p;
    cfg_refl = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("gen_tbl_valid_drop", 64'(tbl_valid), 64'h0);
    n = 0;
    dn = 0;
    while (busy && n < 3000) begin
      n++;
      if (done) dn++;
      if (wild) begin
        cfg_poly = $urandom;
        cfg_refl = ~r;
        start = (n == 100);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("gen_busy_cycles", 64'(n), 64'd2048);
    chk("gen_done_during_busy", 64'(dn), 64'd0);
    chk("gen_done_pulse", 64'(done), 64'h1);
    chk("gen_tbl_valid", 64'(tbl_valid), 64'h1);
    @(negedge clk);
    chk("gen_done_single", 64'(done), 64'h0);
  endtask

  task automatic verify_all(input string tag);
    logic [31:0] d0, d1;
    for (int i = 0; i < 256; i++) begin
      rd2(8'(i), 8'(255-i), d0, d1);
      chk({tag, "_p0"}, 64'(d0), 64'(mt[i]));
      chk({tag, "_p1"}, 64'(d1), 64'(mt[255-i]));
    end
  endtask

  initial begin
    logic [31:0] d0, d1, h0, h1;
    logic [1:0]  pe;
    logic [7:0]  pa0, pa1;
    int          n;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_tbl_valid", 64'(tbl_valid), 64'h0);
    chk("rst_rd_vld", 64'(rd_vld), 64'h0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_err", 64'(rd_err), 64'h0);
    rstn = 1'b1;
    // T1: lookup before any table exists
    @(negedge clk);
    rd_en = 2'b11;
    rd_addr = 16'h0102;
    @(negedge clk);
    rd_en = 2'b00;
    chk("t1_rd_vld", 64'(rd_vld), 64'h0);
    chk("t1_rd_err", 64'(rd_err), 64'h1);
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_tbl_valid", 64'(tbl_valid), 64'h0);
    // T2: reflected CRC-32
    gen(32'h04C11DB7, 1'b1, 1'b0);
    rd2(8'h01, 8'h80, d0, d1);
    chk("t2_01", 64'(d0), 64'h77073096);
    chk("t2_80", 64'(d1), 64'hEDB88320);
    rd2(8'hFF, 8'h00, d0, d1);
    chk("t2_ff", 64'(d0), 64'h2D02EF8D);
    chk("t2_00", 64'(d1), 64'h0);
    chk("t2_rd_err_sticky", 64'(rd_err), 64'h1);
    // T3: normal CRC-32
    gen(32'h04C11DB7, 1'b0, 1'b0);
    rd2(8'h01, 8'h02, d0, d1);
    chk("t3_01", 64'(d0), 64'h04C11DB7);
    chk("t3_02", 64'(d1), 64'h09823B6E);
    rd2(8'hFF, 8'h00, d0, d1);
    chk("t3_ff", 64'(d0), 64'hB1F740B4);
    chk("t3_00", 64'(d1), 64'h0);
    // T4: simultaneous then random back-to-back lookups
    build(32'h04C11DB7, 1'b0);
    rd2(8'hFF, 8'h01, h0, h1);
    chk("t4_p0_ff", 64'(h0), 64'hB1F740B4);
    chk("t4_p1_01", 64'(h1), 64'h04C11DB7);
    pe = 2'b00;
    pa0 = '0;
    pa1 = '0;
    for (int k = 0; k <= 1000; k++) begin
      @(negedge clk);
      h0 = pe[0] ? mt[pa0] : h0;
      h1 = pe[1] ? mt[pa1] : h1;
      chk("t4_vld", 64'(rd_vld), 64'(pe));
      chk("t4_p0", 64'(rd_data[31:0]), 64'(h0));
      chk("t4_p1", 64'(rd_data[63:32]), 64'(h1));
      pe = k == 1000 ? 2'b00 : 2'($urandom);
      pa0 = 8'($urandom);
      pa1 = k[0] ? pa0 : 8'($urandom);
      rd_en = pe;
      rd_addr = {pa1, pa0};
    end
    rd_en = 2'b00;
    // T5: regeneration from READY, config churn and an ignored start during GEN
    gen(32'h1EDC6F41, 1'b1, 1'b1);
    rd2(8'h01, 8'h80, d0, d1);
    chk("t5_01", 64'(d0), 64'hF26B8303);
    chk("t5_80", 64'(d1), 64'h82F63B78);
    build(32'h1EDC6F41, 1'b1);
    verify_all("t5_tbl");
    // T6: reset in the middle of GEN, then restart
    @(negedge clk);
    cfg_poly = 32'h04C11DB7;
    cfg_refl = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("t6_busy_before_rst", 64'(busy), 64'h1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_done", 64'(done), 64'h0);
    chk("t6_rst_tbl_valid", 64'(tbl_valid), 64'h0);
    chk("t6_rst_rd_err", 64'(rd_err), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    gen(32'h04C11DB7, 1'b1, 1'b0);
    build(32'h04C11DB7, 1'b1);
    verify_all("t6_tbl");
    rd2(8'hFF, 8'h01, d0, d1);
    chk("t6_ff", 64'(d0), 64'h2D02EF8D);
    chk("t6_01", 64'(d1), 64'h77073096);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
